ula_arbitro: RTL

ULA_ARBITRO -- requirements
Module: ula_arbitro

---
 rtl/ula_arbitro.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ula_arbitro.sv
// Purpose : round-robin arbiter sharing one external ULA between two requesters.
// Latency : gnt at cycle N, operands on the ULA at N+1, done/result at N+2; one op per 3 cycles.
// Backpr. : requests are ignored while busy; a requester holds req until it sees its gnt pulse.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   req_x, op_x, a_x, b_x      request, operation code and operands of requester x (0/1)
//   gnt_x                      one-cycle acceptance pulse (combinational, OCIOSO only)
//   ula_a, ula_b, ula_ctrl     latched operands/code driven to the shared ULA
//   ula_result, ula_zero       ULA outputs, captured at the end of EXECUTA
//   done_x                     one-cycle completion pulse to the granted requester
//   result, zero               captured ULA outputs, held until the next capture
//   op_invalido                with done_x when the issued code is not a legal ULA operation
//   ocupado                    high while an operation is in flight
module ula_arbitro #(
    parameter int LARGURA = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_0,
    input  logic               req_1,
    input  logic [2:0]         op_0,
    input  logic [2:0]         op_1,
    input  logic [LARGURA-1:0] a_0,
    input  logic [LARGURA-1:0] b_0,
    input  logic [LARGURA-1:0] a_1,
    input  logic [LARGURA-1:0] b_1,
    output logic               gnt_0,
    output logic               gnt_1,
    output logic [LARGURA-1:0] ula_a,
    output logic [LARGURA-1:0] ula_b,
    output logic [2:0]         ula_ctrl,
    input  logic [LARGURA-1:0] ula_result,
    input  logic               ula_zero,
    output logic               done_0,
    output logic               done_1,
    output logic [LARGURA-1:0] result,
    output logic               zero,
    output logic               op_invalido,
    output logic               ocupado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    estado_t estado, prox_estado;

    logic ultimo;   // requester granted most recently; the other one wins a tie
    logic dono;     // requester owning the operation in flight
    logic escolha;  // requester selected in this OCIOSO cycle
    logic concede;  // a grant happens in this cycle

    // Grants and completions are decoded combinationally from the state so that
    // gnt lands in the same cycle the request is seen. Both are suppressed while
    // reset is high so an aborted operation never reports and nothing is granted.
    always_comb begin
        prox_estado = estado;
        gnt_0       = 1'b0;
        gnt_1       = 1'b0;
        done_0      = 1'b0;
        done_1      = 1'b0;
        escolha     = 1'b0;
        concede     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (!reset && (req_0 || req_1)) begin
                    concede     = 1'b1;
                    escolha     = (req_0 && req_1) ? ~ultimo : req_1;
                    gnt_0       = ~escolha;
                    gnt_1       = escolha;
                    prox_estado = EXECUTA;
                end
            end
            EXECUTA: begin
                prox_estado = RESPONDE;
            end
            RESPONDE: begin
                prox_estado = OCIOSO;
                if (!reset) begin
                    done_0 = ~dono;
                    done_1 = dono;
                end
            end
            default: begin
                prox_estado = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado   <= OCIOSO;
            ultimo   <= 1'b1;  // makes requester 0 win the first tie
            dono     <= 1'b0;
            ula_a    <= '0;
            ula_b    <= '0;
            ula_ctrl <= 3'b000;
            result   <= '0;
            zero     <= 1'b0;
        end else begin
            estado <= prox_estado;
            if (concede) begin
                ultimo   <= escolha;
                dono     <= escolha;
                ula_a    <= escolha ? a_1 : a_0;
                ula_b    <= escolha ? b_1 : b_0;
                ula_ctrl <= escolha ? op_1 : op_0;
            end
            if (estado == EXECUTA) begin
                result <= ula_result;
                zero   <= ula_zero;
            end
        end
    end

    assign ocupado = (estado != OCIOSO);

    // ula_ctrl still holds the issued code during RESPONDE; 011 and 101 are the
    // two codes the ULA does not define.
    assign op_invalido = (done_0 || done_1) &&
                         ((ula_ctrl == 3'b011) || (ula_ctrl == 3'b101));

endmodule
